// File: rtl/ddr3_app_responder_if.sv
// MIG 7-series app_* bundle between the user logic (master) and the
// ddr3_app_responder stand-in (slave), including the stall/err test hooks.
interface ddr3_app_responder_if #(
   parameter int ADDR_WIDTH = 28,
   parameter int DATA_WIDTH = 512,
   parameter int MASK_WIDTH = DATA_WIDTH / 8
);
   logic [ADDR_WIDTH-1:0] app_addr;
   logic [2:0]            app_cmd;
   logic                  app_en;
   logic                  app_rdy;
   logic [DATA_WIDTH-1:0] app_wdf_data;
   logic [MASK_WIDTH-1:0] app_wdf_mask;
   logic                  app_wdf_wren;
   logic                  app_wdf_end;
   logic                  app_wdf_rdy;
   logic [DATA_WIDTH-1:0] app_rd_data;
   logic                  app_rd_data_valid;
   logic                  app_rd_data_end;
   logic                  init_calib_complete;
   logic                  stall;
   logic [2:0]            err;

   modport master (
      output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
             app_wdf_wren, app_wdf_end, stall,
      input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
             app_rd_data_end, init_calib_complete, err
   );

   modport slave (
      input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
             app_wdf_wren, app_wdf_end, stall,
      output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
             app_rd_data_end, init_calib_complete, err
   );
endinterface

// File: rtl/ddr3_app_responder.sv
// Synthesizable stand-in for the MIG 7-series UI: calibration delay, write-data
// FIFO, small backing memory and fixed-latency in-order read return.
module ddr3_app_responder #(
   parameter int ADDR_WIDTH   = 28,
   parameter int DATA_WIDTH   = 512,
   parameter int MASK_WIDTH   = 64,
   parameter int MEM_AW       = 8,
   parameter int WDF_DEPTH    = 4,
   parameter int RD_LATENCY   = 4,
   parameter int CALIB_CYCLES = 16
) (
   input logic              clk,
   input logic              rst,
   ddr3_app_responder_if.slave app
);
   localparam int PW = (WDF_DEPTH > 1) ? $clog2(WDF_DEPTH) : 1;
   localparam int CW = $clog2(WDF_DEPTH + 1);
   localparam int KW = $clog2(CALIB_CYCLES + 1);
   localparam logic [CW-1:0] WDF_FULL   = CW'(WDF_DEPTH);
   localparam logic [KW-1:0] CALIB_LAST = KW'(CALIB_CYCLES - 1);
   localparam logic [2:0]    CMD_WRITE  = 3'b000;
   localparam logic [2:0]    CMD_READ   = 3'b001;

   typedef enum logic {
      ST_IDLE      = 1'b0,
      ST_WAIT_DATA = 1'b1
   } wr_state_t;

   wr_state_t             r_state;
   logic [MEM_AW-1:0]     r_wr_idx;
   logic                  r_calib;
   logic [KW-1:0]         r_calib_cnt;
   logic [DATA_WIDTH-1:0] r_wdf_data [WDF_DEPTH];
   logic [MASK_WIDTH-1:0] r_wdf_mask [WDF_DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_wdf_cnt;
   logic [DATA_WIDTH-1:0] r_mem [2**MEM_AW];
   logic [RD_LATENCY-1:0] r_rd_vld;
   logic [DATA_WIDTH-1:0] r_rd_pipe [RD_LATENCY];
   logic                  r_rd_out_vld;
   logic [DATA_WIDTH-1:0] r_rd_out;
   logic [2:0]            r_err;

   logic                  w_rdy;
   logic                  w_wdf_rdy;
   logic                  w_cmd_acc;
   logic                  w_data_acc;
   logic                  w_wr_cmd;
   logic                  w_rd_cmd;
   logic                  w_fifo_empty;
   logic                  w_commit;
   logic [MEM_AW-1:0]     w_cmd_idx;
   logic [MEM_AW-1:0]     w_commit_idx;
   logic [DATA_WIDTH-1:0] w_commit_data;
   logic [MASK_WIDTH-1:0] w_commit_mask;

   assign w_rdy        = r_calib && (r_state == ST_IDLE) && !app.stall;
   assign w_wdf_rdy    = r_calib && (r_wdf_cnt != WDF_FULL);
   assign w_cmd_acc    = app.app_en && w_rdy;
   assign w_data_acc   = app.app_wdf_wren && w_wdf_rdy;
   assign w_wr_cmd     = w_cmd_acc && (app.app_cmd == CMD_WRITE);
   assign w_rd_cmd     = w_cmd_acc && (app.app_cmd == CMD_READ);
   assign w_cmd_idx    = app.app_addr[3 +: MEM_AW];
   assign w_fifo_empty = (r_wdf_cnt == '0);

   // An empty FIFO means the beat being accepted this cycle is the one to commit.
   assign w_commit      = (w_wr_cmd && (!w_fifo_empty || w_data_acc)) ||
                          ((r_state == ST_WAIT_DATA) && w_data_acc);
   assign w_commit_idx  = (r_state == ST_WAIT_DATA) ? r_wr_idx : w_cmd_idx;
   assign w_commit_data = w_fifo_empty ? app.app_wdf_data : r_wdf_data[r_rd_ptr];
   assign w_commit_mask = w_fifo_empty ? app.app_wdf_mask : r_wdf_mask[r_rd_ptr];

   // Write-command FSM: a command with no data parks its index until a beat arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_wr_idx <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples pre-edge values, regardless of statement order.
         case (r_state)
            ST_IDLE: begin
               if (w_wr_cmd && !w_commit) begin
                  r_state  <= ST_WAIT_DATA;
                  r_wr_idx <= w_cmd_idx;
               end
            end
            ST_WAIT_DATA: begin
               if (w_data_acc) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_calib_cnt <= '0;
         r_calib     <= 1'b0;
      end else if (!r_calib) begin
         r_calib_cnt <= r_calib_cnt + 1'b1;
         if (r_calib_cnt == CALIB_LAST) r_calib <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_wdf_cnt <= '0;
      end else begin
         if (w_data_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_commit)   r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_data_acc, w_commit})
            2'b10:   r_wdf_cnt <= r_wdf_cnt + 1'b1;
            2'b01:   r_wdf_cnt <= r_wdf_cnt - 1'b1;
            default: r_wdf_cnt <= r_wdf_cnt;
         endcase
      end
   end

   // NOTE: storage arrays (FIFO slots, backing memory, read data pipe) carry no
   // reset; their contents are only meaningful behind the reset-cleared pointers
   // and valid bits, and the memory must survive rst.
   always_ff @(posedge clk) begin
      if (w_data_acc) begin
         r_wdf_data[r_wr_ptr] <= app.app_wdf_data;
         r_wdf_mask[r_wr_ptr] <= app.app_wdf_mask;
      end
      if (w_commit) begin
         for (int b = 0; b < MASK_WIDTH; b++) begin
            if (!w_commit_mask[b]) r_mem[w_commit_idx][b*8 +: 8] <= w_commit_data[b*8 +: 8];
         end
      end
      if (w_rd_cmd) r_rd_pipe[0] <= r_mem[w_cmd_idx];
      for (int k = 1; k < RD_LATENCY; k++) r_rd_pipe[k] <= r_rd_pipe[k-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_vld     <= '0;
         r_rd_out_vld <= 1'b0;
         r_rd_out     <= '0;
      end else begin
         r_rd_vld[0] <= w_rd_cmd;
         for (int k = 1; k < RD_LATENCY; k++) r_rd_vld[k] <= r_rd_vld[k-1];
         r_rd_out_vld <= r_rd_vld[RD_LATENCY-1];
         if (r_rd_vld[RD_LATENCY-1]) r_rd_out <= r_rd_pipe[RD_LATENCY-1];
      end
   end

   // Sticky protocol errors: {wdf_end_err, addr_err, cmd_err}.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= '0;
      end else begin
         r_err <= r_err | {w_data_acc && !app.app_wdf_end,
                           w_cmd_acc && (app.app_addr[2:0] != 3'b000),
                           w_cmd_acc && (app.app_cmd > CMD_READ)};
      end
   end

   assign app.app_rdy             = w_rdy;
   assign app.app_wdf_rdy         = w_wdf_rdy;
   assign app.app_rd_data         = r_rd_out;
   assign app.app_rd_data_valid   = r_rd_out_vld;
   assign app.app_rd_data_end     = r_rd_out_vld;
   assign app.init_calib_complete = r_calib;
   assign app.err                 = r_err;
endmodule

// File: tb/tb_ddr3_app_responder.sv
// Directed bench for ddr3_app_responder: calibration, write/read paths, FIFO,
// masking, aliasing, error flags, stall and mid-read reset.
module tb_ddr3_app_responder;
   localparam int AW  = 28;
   localparam int DW  = 512;
   localparam int MW  = 64;
   localparam int LAT = 4;
   localparam int CAL = 16;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [DW-1:0] a_beat [4];
   logic [DW-1:0] masked_word;
   logic [7:0]    bb;

   ddr3_app_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) app_if ();

   ddr3_app_responder #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .MEM_AW(8),
      .WDF_DEPTH(4), .RD_LATENCY(LAT), .CALIB_CYCLES(CAL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .app(app_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      app_if.app_en       = 1'b0;
      app_if.app_cmd      = 3'b000;
      app_if.app_addr     = '0;
      app_if.app_wdf_wren = 1'b0;
      app_if.app_wdf_end  = 1'b0;
      app_if.app_wdf_data = '0;
      app_if.app_wdf_mask = '0;
      app_if.stall        = 1'b0;
   endtask

   task automatic write_same(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [MW-1:0] mask);
      app_if.app_en       = 1'b1;
      app_if.app_cmd      = 3'b000;
      app_if.app_addr     = addr;
      app_if.app_wdf_wren = 1'b1;
      app_if.app_wdf_end  = 1'b1;
      app_if.app_wdf_data = data;
      app_if.app_wdf_mask = mask;
      tick();
      idle_inputs();
   endtask

   task automatic read_expect(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
      app_if.app_en   = 1'b1;
      app_if.app_cmd  = 3'b001;
      app_if.app_addr = addr;
      tick();
      app_if.app_en = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         tick();
         if (k < LAT) begin
            check({tag, "_early_valid"}, app_if.app_rd_data_valid, 1'b0);
         end else begin
            check({tag, "_valid"}, app_if.app_rd_data_valid, 1'b1);
            check({tag, "_end"}, app_if.app_rd_data_end, 1'b1);
            check({tag, "_data"}, app_if.app_rd_data, exp);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 4; i++) begin
         bb = 8'h11 * 8'(i + 1);
         a_beat[i] = {64{bb}};
      end
      masked_word = {{63{8'hAA}}, 8'h55};

      // Reset state and calibration delay.
      rst = 1'b1;
      idle_inputs();
      repeat (3) tick();
      check("rst_calib", app_if.init_calib_complete, 1'b0);
      check("rst_rdy", app_if.app_rdy, 1'b0);
      check("rst_wdf_rdy", app_if.app_wdf_rdy, 1'b0);
      check("rst_valid", app_if.app_rd_data_valid, 1'b0);
      check("rst_end", app_if.app_rd_data_end, 1'b0);
      check("rst_data", app_if.app_rd_data, '0);
      check("rst_err", app_if.err, 3'b000);
      rst = 1'b0;
      for (int i = 1; i < CAL; i++) begin
         tick();
         check("cal_pending", app_if.init_calib_complete, 1'b0);
         check("cal_rdy_low", app_if.app_rdy, 1'b0);
         check("cal_wdf_rdy_low", app_if.app_wdf_rdy, 1'b0);
      end
      tick();
      check("cal_done", app_if.init_calib_complete, 1'b1);
      check("cal_rdy", app_if.app_rdy, 1'b1);
      check("cal_wdf_rdy", app_if.app_wdf_rdy, 1'b1);

      // Command and data in the same cycle, then read back with fixed latency.
      write_same(28'h0000f00, 512'h50805080, '0);
      read_expect("t2", 28'h0000f00, 512'h50805080);
      tick();
      check("t2_valid_drop", app_if.app_rd_data_valid, 1'b0);
      check("t2_data_hold", app_if.app_rd_data, 512'h50805080);

      // Write command ahead of its data.
      app_if.app_en   = 1'b1;
      app_if.app_cmd  = 3'b000;
      app_if.app_addr = 28'h10;
      tick();
      app_if.app_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t3_rdy_blocked", app_if.app_rdy, 1'b0);
         if (i < 2) tick();
      end
      app_if.app_wdf_wren = 1'b1;
      app_if.app_wdf_end  = 1'b1;
      app_if.app_wdf_data = 512'hdead_beef_0000_0010;
      tick();
      idle_inputs();
      check("t3_rdy_back", app_if.app_rdy, 1'b1);
      check("t3_wdf_rdy", app_if.app_wdf_rdy, 1'b1);
      read_expect("t3", 28'h10, 512'hdead_beef_0000_0010);

      // Data ahead of commands: fill the FIFO, overflow attempt, then drain in order.
      for (int i = 0; i < 4; i++) begin
         app_if.app_wdf_wren = 1'b1;
         app_if.app_wdf_end  = 1'b1;
         app_if.app_wdf_data = a_beat[i];
         tick();
      end
      check("t4_full", app_if.app_wdf_rdy, 1'b0);
      app_if.app_wdf_data = {16{32'hbad0_bad0}};
      tick();
      idle_inputs();
      check("t4_still_full", app_if.app_wdf_rdy, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("t4_cmd_rdy", app_if.app_rdy, 1'b1);
         app_if.app_en   = 1'b1;
         app_if.app_cmd  = 3'b000;
         app_if.app_addr = AW'(i * 8);
         tick();
      end
      idle_inputs();
      check("t4_drained", app_if.app_wdf_rdy, 1'b1);
      for (int i = 0; i < 4; i++) begin
         app_if.app_en   = 1'b1;
         app_if.app_cmd  = 3'b001;
         app_if.app_addr = AW'(i * 8);
         tick();
      end
      idle_inputs();
      check("t4_not_yet", app_if.app_rd_data_valid, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t4_b2b_valid", app_if.app_rd_data_valid, 1'b1);
         check("t4_b2b_data", app_if.app_rd_data, a_beat[i]);
      end
      tick();
      check("t4_b2b_done", app_if.app_rd_data_valid, 1'b0);

      // Byte mask, then address aliasing above the memory index.
      write_same(28'h20, {64{8'hAA}}, '0);
      write_same(28'h20, {64{8'h55}}, 64'hFFFF_FFFF_FFFF_FFFE);
      read_expect("t5_mask", 28'h20, masked_word);
      read_expect("t5_alias_lo", 28'h0000820, masked_word);
      read_expect("t5_alias_hi", 28'h8000020, masked_word);

      // Error flags, stall, and reset during a read.
      app_if.app_en   = 1'b1;
      app_if.app_cmd  = 3'b010;
      app_if.app_addr = 28'h0;
      tick();
      idle_inputs();
      check("t6_cmd_err", app_if.err, 3'b001);
      check("t6_illegal_no_block", app_if.app_rdy, 1'b1);
      read_expect("t6_low_bits", 28'h3, a_beat[0]);
      check("t6_addr_err", app_if.err, 3'b011);
      app_if.app_wdf_wren = 1'b1;
      app_if.app_wdf_end  = 1'b0;
      app_if.app_wdf_data = {16{32'h0bad_0bad}};
      tick();
      idle_inputs();
      check("t6_end_err", app_if.err, 3'b111);

      app_if.stall    = 1'b1;
      app_if.app_en   = 1'b1;
      app_if.app_cmd  = 3'b001;
      app_if.app_addr = 28'h20;
      #1;
      check("t6_stall_rdy", app_if.app_rdy, 1'b0);
      for (int i = 0; i < LAT + 2; i++) begin
         tick();
         check("t6_stall_no_read", app_if.app_rd_data_valid, 1'b0);
      end
      idle_inputs();
      #1;
      check("t6_unstall_rdy", app_if.app_rdy, 1'b1);

      app_if.app_en   = 1'b1;
      app_if.app_cmd  = 3'b001;
      app_if.app_addr = 28'h20;
      tick();
      idle_inputs();
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_rst_err", app_if.err, 3'b000);
      check("t6_rst_data", app_if.app_rd_data, '0);
      check("t6_rst_calib", app_if.init_calib_complete, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("t6_rst_no_valid", app_if.app_rd_data_valid, 1'b0);
      end
      repeat (CAL) tick();
      check("t6_recal", app_if.init_calib_complete, 1'b1);
      read_expect("t6_mem_kept", 28'h20, masked_word);

      // The stray beat queued before reset must be gone: a bare write command waits.
      app_if.app_en   = 1'b1;
      app_if.app_cmd  = 3'b000;
      app_if.app_addr = 28'h28;
      tick();
      idle_inputs();
      check("t6_fifo_flushed", app_if.app_rdy, 1'b0);
      app_if.app_wdf_wren = 1'b1;
      app_if.app_wdf_end  = 1'b1;
      app_if.app_wdf_data = 512'h2828;
      tick();
      idle_inputs();
      read_expect("t6_post_rst_write", 28'h28, 512'h2828);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
